// File: rtl/acca_pkg.sv
// rtl/acca_pkg.sv - shared types and constants for the sequential ACCA multiplier controller
package acca_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LL   = 3'd1,
    S_LH   = 3'd2,
    S_HL   = 3'd3,
    S_HH   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int Q_LL = 0;
  localparam int Q_LH = 1;
  localparam int Q_HL = 2;
  localparam int Q_HH = 3;

  localparam logic [3:0] SH_LL = 4'd0;
  localparam logic [3:0] SH_LH = 4'd4;
  localparam logic [3:0] SH_HL = 4'd4;
  localparam logic [3:0] SH_HH = 4'd8;

  localparam logic [7:0] AP_MASK = 8'hFC;

  function automatic state_t quad_state(input int q);
    case (q)
      Q_LL:    return S_LL;
      Q_LH:    return S_LH;
      Q_HL:    return S_HL;
      Q_HH:    return S_HH;
      default: return S_DONE;
    endcase
  endfunction

  // First quadrant at or after index 'first' that is not skipped, else DONE.
  function automatic state_t next_quad(input logic [3:0] skip, input int first);
    state_t r;
    r = S_DONE;
    for (int i = 3; i >= 0; i--) begin
      if (i >= first && !skip[i]) r = quad_state(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ap_q4.sv
// rtl/ap_q4.sv - shared 4x4 partial-product unit with optional low-bit truncation
module ap_q4
  import acca_pkg::*;
(
  input  logic [3:0] i_x,
  input  logic [3:0] i_y,
  input  logic       i_approx_en,
  output logic [7:0] o_pp
);

  logic [7:0] w_exact;

  assign w_exact = {4'd0, i_x} * {4'd0, i_y};
  assign o_pp    = i_approx_en ? (w_exact & AP_MASK) : w_exact;

endmodule

// File: rtl/acca_seq_ctrl.sv
// rtl/acca_seq_ctrl.sv - sequential 8x8 approximate multiplier, one quadrant per cycle
module acca_seq_ctrl
  import acca_pkg::*;
#(
  parameter int SKIP_ZERO = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [3:0]       cfg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [3:0]       r_cfg;
  logic [3:0]       r_skip;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_skip_in;
  logic [3:0]       w_x;
  logic [3:0]       w_y;
  logic [3:0]       w_sh;
  logic             w_approx;
  logic             w_compute;
  logic [7:0]       w_pp;
  logic             w_accept;
  logic             w_consume;

  // A zero nibble on either side makes that quadrant's product zero, so it is skipped.
  assign w_skip_in = (SKIP_ZERO != 0) ?
                     {(a[7:4] == 4'd0) || (b[7:4] == 4'd0),
                      (a[7:4] == 4'd0) || (b[3:0] == 4'd0),
                      (a[3:0] == 4'd0) || (b[7:4] == 4'd0),
                      (a[3:0] == 4'd0) || (b[3:0] == 4'd0)} : 4'b0000;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign prod      = out_valid ? r_acc : 16'd0;
  assign op_count  = r_cnt;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_comb begin
    w_x       = r_a[3:0];
    w_y       = r_b[3:0];
    w_sh      = SH_LL;
    w_approx  = r_cfg[Q_LL];
    w_compute = 1'b0;
    case (r_state)
      S_LL: begin
        w_compute = 1'b1;
      end
      S_LH: begin
        w_y       = r_b[7:4];
        w_sh      = SH_LH;
        w_approx  = r_cfg[Q_LH];
        w_compute = 1'b1;
      end
      S_HL: begin
        w_x       = r_a[7:4];
        w_sh      = SH_HL;
        w_approx  = r_cfg[Q_HL];
        w_compute = 1'b1;
      end
      S_HH: begin
        w_x       = r_a[7:4];
        w_y       = r_b[7:4];
        w_sh      = SH_HH;
        w_approx  = r_cfg[Q_HH];
        w_compute = 1'b1;
      end
      default: begin
        w_compute = 1'b0;
      end
    endcase
  end

  ap_q4 u_ap_q4 (
    .i_x         (w_x),
    .i_y         (w_y),
    .i_approx_en (w_approx),
    .o_pp        (w_pp)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = next_quad(w_skip_in, Q_LL);
      S_LL:    w_state_nxt = next_quad(r_skip, Q_LH);
      S_LH:    w_state_nxt = next_quad(r_skip, Q_HL);
      S_HL:    w_state_nxt = next_quad(r_skip, Q_HH);
      S_HH:    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_cfg  <= 4'd0;
      r_skip <= 4'd0;
      r_acc  <= 16'd0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_cfg  <= cfg;
        r_skip <= w_skip_in;
        r_acc  <= 16'd0;
      end else if (w_compute) begin
        r_acc  <= r_acc + ({8'd0, w_pp} << w_sh);
      end
      if (w_consume) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
